// File: rtl/reaction_ctrl_fsm.sv
// Reaction-timer control unit: sequences the ms BCD counter, status LED and display enable.
// Latency: rgb/rs_en/err_code are registered (follow the state edge); cnt_clr/cnt_en are combinational.
// Backpressure: none; start/enter are single-cycle pulses consumed in the cycle they arrive.
// Ports: clk/rst (sync, active-high); start, enter (debounced pulses); cnt_max (counter at 9999);
//        cnt_clr, cnt_en (counter controls); rgb_r/g/b (LED); rs_en (display enable);
//        err_code (0 none, 1 early press, 2 timeout).
module reaction_ctrl_fsm #(
    parameter int          CLKS_PER_MS  = 100000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enter,
    input  logic       cnt_max,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       rgb_r,
    output logic       rgb_g,
    output logic       rgb_b,
    output logic       rs_en,
    output logic [1:0] err_code
);

    localparam int PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
    // Wide enough for the largest arm delay MIN_DELAY_MS + 2^RAND_BITS - 1.
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        TIMING  = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   lfsr;
    logic [PW-1:0] prescaler;
    logic [DW-1:0] delay;
    logic          ms_tick;
    logic          enter_wait;
    logic          enter_timing;

    assign ms_tick      = (prescaler == PW'(CLKS_PER_MS - 1));
    assign enter_wait   = (state_nxt == WAIT) && (state != WAIT);
    assign enter_timing = (state_nxt == TIMING) && (state != TIMING);

    // Output decode for a given state: {r, g, b, rs_en, err_code}.
    function automatic logic [5:0] decode(input state_t s);
        case (s)
            IDLE:    decode = 6'b000_0_00;
            WAIT:    decode = 6'b001_0_00;
            TIMING:  decode = 6'b010_1_00;
            DONE:    decode = 6'b000_1_00;
            EARLY:   decode = 6'b100_1_01;
            TIMEOUT: decode = 6'b100_1_10;
            default: decode = 6'b000_0_00;
        endcase
    endfunction

    // Next state. enter beats the WAIT->TIMING hand-off and the timeout check;
    // start is only honoured in the resting states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, EARLY, TIMEOUT: begin
                if (start) state_nxt = WAIT;
            end
            WAIT: begin
                if (enter)                            state_nxt = EARLY;
                else if (ms_tick && delay == DW'(1))  state_nxt = TIMING;
            end
            TIMING: begin
                if (enter)                 state_nxt = DONE;
                else if (ms_tick && cnt_max) state_nxt = TIMEOUT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset is not a start acceptance, so it never clears the counter.
    assign cnt_clr = !rst && enter_wait;
    // A tick coinciding with enter or with the counter saturated is not counted.
    assign cnt_en  = !rst && (state == TIMING) && ms_tick && !enter && !cnt_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            prescaler <= '0;
            delay     <= '0;
            rgb_r     <= 1'b0;
            rgb_g     <= 1'b0;
            rgb_b     <= 1'b0;
            rs_en     <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state <= state_nxt;
            {rgb_r, rgb_g, rgb_b, rs_en, err_code} <= decode(state_nxt);

            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            // Restart the ms phase on WAIT/TIMING entry so both phases are
            // whole multiples of CLKS_PER_MS long.
            if (enter_wait || enter_timing || ms_tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;

            // Arm delay uses the LFSR value present at the accepting edge.
            if (enter_wait)
                delay <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
            else if (state == WAIT && ms_tick)
                delay <= delay - 1'b1;
        end
    end

endmodule

// File: doc/reaction_ctrl_fsm.md
Name: reaction_ctrl_fsm

Overview:
- Control unit for the reaction-timer game.
- Sequences the millisecond BCD counter datapath (clear/enable), the RGB status LED and the display enable (rs_en).
- Runs an internal millisecond prescaler and an LFSR-based random arm delay.
- Sits between the debounced pushbutton pulses (start, enter) and the BCD counter / seven-segment display mux.

Parameters:
- CLKS_PER_MS, 100000, clock cycles per 1 ms tick (>=2)
- MIN_DELAY_MS, 1000, minimum random delay before the go signal, in ms
- RAND_BITS, 11, number of LFSR bits added to MIN_DELAY_MS (delay range MIN..MIN+2^RAND_BITS-1)
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle debounced start pulse
- enter  input  1  single-cycle debounced reaction pulse
- cnt_max  input  1  datapath BCD counter reads 9999
- cnt_clr  output  1  clear BCD counter (one-cycle pulse)
- cnt_en  output  1  increment BCD counter by 1 ms (one-cycle pulse)
- rgb_r  output  1  red LED
- rgb_g  output  1  green LED
- rgb_b  output  1  blue LED
- rs_en  output  1  display enable
- err_code  output  2  0=none, 1=early press, 2=timeout, 3 unused

Behaviour:
- Reset: state=IDLE, lfsr=LFSR_SEED, prescaler=0, delay counter=0.
  - Outputs after reset: cnt_clr=0, cnt_en=0, rgb=000, rs_en=0, err_code=0.
- LFSR: 16-bit Fibonacci, advances every clk while not in reset. lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1, wraps to 0.
  - ms_tick = (prescaler==CLKS_PER_MS-1).
  - Forced to 0 on every transition into WAIT and into TIMING.
- States. rgb, rs_en and err_code are decoded from the state register.
  - IDLE: rgb=000, rs_en=0, err=0. start -> WAIT.
  - WAIT: rgb=001 (blue, get ready), rs_en=0, err=0.
    - On entry: delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the lfsr value present at the accepting edge.
    - The delay counter decrements on each ms_tick; ms_tick with delay==1 -> TIMING. WAIT therefore lasts exactly delay_ms*CLKS_PER_MS cycles.
    - enter -> EARLY. enter has priority over the same-cycle transition to TIMING.
    - start is ignored.
  - TIMING: rgb=010 (green), rs_en=1, err=0.
    - enter -> DONE.
    - ms_tick & cnt_max & !enter -> TIMEOUT.
    - start is ignored.
  - DONE: rgb=000, rs_en=1, err=0. Holds the displayed time. start -> WAIT.
  - EARLY: rgb=100, rs_en=1, err=1. start -> WAIT.
  - TIMEOUT: rgb=100, rs_en=1, err=2. start -> WAIT.
- cnt_clr (combinational):
  - 1 in the cycle where start is accepted, i.e. in IDLE, DONE, EARLY or TIMEOUT.
  - The counter reads 0 from WAIT entry onward.
- cnt_en (combinational): (state==TIMING) & ms_tick & !enter & !cnt_max. An enter coincident with a tick does not count that tick.
- Simultaneous start & enter:
  - In IDLE/DONE/EARLY/TIMEOUT, start wins and enter is ignored.
  - In WAIT/TIMING, enter wins.
- rst mid-operation: rst overrides everything. Next state is IDLE and outputs return to reset values on the following edge. cnt_clr is not asserted by reset.
- No latches; every state has a default. Illegal encodings go to IDLE.

Test Plan:
Use CLKS_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2, LFSR_SEED=16'hACE1.
- Reset then idle: rst high 2 cycles, then low 10 cycles, no stimulus -> rgb=000, rs_en=0, err_code=0, cnt_clr=cnt_en=0 throughout.
- Normal round:
  - Stimulus: start pulsed on the first edge after rst release (lfsr=ACE1, low bits 01) -> cnt_clr=1 for that cycle; delay 3 ms.
  - rgb=001 for exactly 12 cycles, then rgb=010, rs_en=1.
  - enter after 5 ticks -> exactly 5 cnt_en pulses, state DONE, rgb=000, rs_en=1, err_code=0.
- Early press: start, then enter 3 cycles later while blue -> rgb=100, err_code=1, zero cnt_en pulses. A following start -> cnt_clr pulse and rgb=001.
- Timeout: in TIMING, hold cnt_max=1 -> at the next ms_tick state=TIMEOUT, rgb=100, err_code=2, no cnt_en on that tick.
- Coincidence and ignore rules:
  - enter on the same cycle as a TIMING ms_tick -> DONE, no cnt_en that cycle.
  - start during WAIT and during TIMING -> no state change and no cnt_clr.
- Reset mid-TIMING: assert rst during TIMING -> next cycle rgb=000, rs_en=0, err_code=0, lfsr=ACE1.
